// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter that shares a 4:1 multiplexer among four requesters.
// It drives a one-hot grant and the registered mux selects {address1,address0}.
// A hold counter forces release after MAX_HOLD consecutive cycles so that
// a persistent requester cannot starve the others.
module mux_rr_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic       address0,
  output logic       address1,
  output logic       busy
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;
  localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

  logic [0:0] state_q, state_d;
  logic [1:0] own_q, own_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] addr_q, addr_d;
  logic [7:0] hcnt_q, hcnt_d;
  logic [3:0] grant_q, grant_d;

  logic [3:0] own_mask;
  logic [3:0] others;
  logic [1:0] idle_pick;
  logic [1:0] next_pick;

  // First index with its request bit set, scanning start, start+1, ... mod 4.
  // Scanning from the far end lets the nearest hit overwrite the result.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] start);
    logic [1:0] idx;
    logic [1:0] res;
    res = start;
    for (int k = 3; k >= 0; k--) begin
      idx = start + 2'(k);
      if (r[idx]) res = idx;
    end
    return res;
  endfunction

  assign own_mask  = 4'b0001 << own_q;
  assign others    = req & ~own_mask;
  assign idle_pick = rr_pick(req, ptr_q);
  assign next_pick = rr_pick(others, own_q + 2'd1);

  // Next-state logic: start a grant from IDLE, keep/extend it, or hand it over.
  always_comb begin
    state_d = state_q;
    own_d   = own_q;
    ptr_d   = ptr_q;
    addr_d  = addr_q;
    hcnt_d  = hcnt_q;
    grant_d = grant_q;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          own_d   = idle_pick;
          grant_d = 4'b0001 << idle_pick;
          addr_d  = idle_pick;
          hcnt_d  = 8'd1;
          state_d = ST_GRANT;
        end
      end
      default: begin
        if (req[own_q] && (hcnt_q < HOLD_MAX)) begin
          hcnt_d = hcnt_q + 8'd1;
        end else begin
          // Release: the next search always starts just past the old owner.
          ptr_d = own_q + 2'd1;
          if (|others) begin
            own_d   = next_pick;
            grant_d = 4'b0001 << next_pick;
            addr_d  = next_pick;
            hcnt_d  = 8'd1;
          end else if (req[own_q]) begin
            // Forced release with nobody waiting: restart the same owner.
            hcnt_d = 8'd1;
          end else begin
            // Nobody wants the mux; selects keep the last index.
            grant_d = 4'b0000;
            hcnt_d  = 8'd0;
            state_d = ST_IDLE;
          end
        end
      end
    endcase
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      own_q   <= 2'd0;
      ptr_q   <= 2'd0;
      addr_q  <= 2'd0;
      hcnt_q  <= 8'd0;
      grant_q <= 4'b0000;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      hcnt_q  <= hcnt_d;
      grant_q <= grant_d;
    end
  end

  assign grant    = grant_q;
  assign address0 = addr_q[0];
  assign address1 = addr_q[1];
  assign busy     = |grant_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter: table of per-cycle vectors plus
// hand-written multi-cycle sequences, all routed through an expectation queue.
module tb_mux_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req8 = 4'b0000;
  logic [3:0] req1 = 4'b0000;
  logic [3:0] grant8, grant1;
  logic       a0_8, a1_8, busy8;
  logic       a0_1, a1_1, busy1;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] addr;
  } vec_t;

  typedef struct packed {
    logic [3:0] grant;
    logic [1:0] addr;
    logic       busy;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[20];

  // Mux data inputs in0..in3 = 0,1,0,1 for the data-path check.
  logic [3:0] din = 4'b1010;

  mux_rr_arbiter #(.MAX_HOLD(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .req(req8), .grant(grant8),
    .address0(a0_8), .address1(a1_8), .busy(busy8)
  );

  mux_rr_arbiter #(.MAX_HOLD(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req1), .grant(grant1),
    .address0(a0_1), .address1(a1_1), .busy(busy1)
  );

  always #500 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, expv, $time);
    end
  endtask

  // One cycle on the MAX_HOLD=8 instance: drive, queue expectation, compare.
  task automatic step8(input logic [3:0] r, input logic [3:0] eg, input logic [1:0] ea,
                       input string tag);
    exp_t e;
    @(negedge clk);
    req8 = r;
    e.grant = eg;
    e.addr  = ea;
    e.busy  = |eg;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk({tag, "_queue_empty"}, 8'd1, 8'd0);
    end else begin
      e = sb.pop_front();
      $display("txn %s req=%b grant=%b addr=%b%b busy=%b", tag, r, grant8, a1_8, a0_8, busy8);
      chk({tag, "_grant"}, {4'd0, grant8}, {4'd0, e.grant});
      chk({tag, "_addr"}, {6'd0, a1_8, a0_8}, {6'd0, e.addr});
      chk({tag, "_busy"}, {7'd0, busy8}, {7'd0, e.busy});
      chk({tag, "_onehot"}, {7'd0, $onehot0(grant8)}, 8'd1);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_grant8"}, {4'd0, grant8}, 8'd0);
    chk({tag, "_addr8"}, {6'd0, a1_8, a0_8}, 8'd0);
    chk({tag, "_busy8"}, {7'd0, busy8}, 8'd0);
    chk({tag, "_grant1"}, {4'd0, grant1}, 8'd0);
  endtask

  initial begin
    logic [3:0] eg;
    logic [1:0] ea;
    int own;
    exp_t e;

    // req, expected grant, expected {address1,address0}
    vecs[0]  = '{4'b0100, 4'b0100, 2'd2};  // single request
    vecs[1]  = '{4'b0000, 4'b0000, 2'd2};  // release, select held
    vecs[2]  = '{4'b0011, 4'b0001, 2'd0};  // ptr=3 scan reaches 0
    vecs[3]  = '{4'b0011, 4'b0001, 2'd0};
    vecs[4]  = '{4'b0011, 4'b0001, 2'd0};
    vecs[5]  = '{4'b0010, 4'b0010, 2'd1};  // early release to owner 1
    vecs[6]  = '{4'b0010, 4'b0010, 2'd1};
    vecs[7]  = '{4'b0000, 4'b0000, 2'd1};  // idle, select held
    vecs[8]  = '{4'b0001, 4'b0001, 2'd0};  // owner 0 again
    vecs[9]  = '{4'b0000, 4'b0000, 2'd0};
    vecs[10] = '{4'b0001, 4'b0001, 2'd0};  // ptr=1 wraps to 0
    vecs[11] = '{4'b0100, 4'b0100, 2'd2};  // new req joins release edge
    vecs[12] = '{4'b0110, 4'b0100, 2'd2};  // competitor waits
    vecs[13] = '{4'b0100, 4'b0100, 2'd2};  // ungranted drop ignored
    vecs[14] = '{4'b0000, 4'b0000, 2'd2};
    vecs[15] = '{4'b0011, 4'b0001, 2'd0};  // ptr=3
    vecs[16] = '{4'b0000, 4'b0000, 2'd0};
    vecs[17] = '{4'b0011, 4'b0010, 2'd1};  // ptr=1 favours 1 over 0
    vecs[18] = '{4'b0000, 4'b0000, 2'd1};
    vecs[19] = '{4'b1000, 4'b1000, 2'd3};

    // Reset state with no clock edge yet.
    #100;
    check_reset_outputs("reset_initial");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      step8(vecs[i].req, vecs[i].grant, vecs[i].addr, $sformatf("vec%0d", i));
    end
    step8(4'b0000, 4'b0000, 2'd3, "vec_idle_tail");

    // Reset in the middle of a grant to owner 2: outputs clear without an edge.
    step8(4'b0100, 4'b0100, 2'd2, "pre_reset_grant");
    @(negedge clk);
    #200;
    rst_n = 1'b0;
    #10;
    check_reset_outputs("reset_midgrant");
    req8 = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;

    // All four requesting continuously: 8-cycle slots, 0,1,2,3,0,1.
    for (int k = 0; k < 41; k++) begin
      own = (k / 8) % 4;
      eg = 4'b0001 << own;
      ea = 2'(own);
      step8(4'b1111, eg, ea, $sformatf("all_req_c%0d", k));
    end
    step8(4'b0000, 4'b0000, 2'd1, "all_req_drop");

    // Sole requester 3 re-granted across forced releases; req[1] joins at 12.
    rst_n = 1'b0;
    #10;
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (k < 16) begin
        eg = 4'b1000;
        ea = 2'd3;
      end else begin
        eg = 4'b0010;
        ea = 2'd1;
      end
      step8((k >= 12) ? 4'b1010 : 4'b1000, eg, ea, $sformatf("sole_c%0d", k));
    end
    step8(4'b0000, 4'b0000, 2'd1, "sole_drop");

    // MAX_HOLD=1: grant rotates every cycle, mux out alternates 0,1,0,1.
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      req1 = 4'b1111;
      e.grant = 4'b0001 << (k % 4);
      e.addr  = 2'(k % 4);
      e.busy  = 1'b1;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      $display("txn rot_c%0d grant=%b addr=%b%b out=%b", k, grant1, a1_1, a0_1, din[{a1_1, a0_1}]);
      chk($sformatf("rot_c%0d_grant", k), {4'd0, grant1}, {4'd0, e.grant});
      chk($sformatf("rot_c%0d_out", k), {7'd0, din[{a1_1, a0_1}]}, 8'(k % 2));
      chk($sformatf("rot_c%0d_busy", k), {7'd0, busy1}, {7'd0, e.busy});
      chk($sformatf("rot_c%0d_onehot", k), {7'd0, $onehot0(grant1)}, 8'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux_rr_arbiter.md
# mux_rr_arbiter

Round-robin arbiter that shares the 4:1 multiplexer among four requesters. It samples per-input requests, grants one requester at a time, and drives the mux select lines `address1` and `address0` so the granted input reaches `out`. A hold limit bounds how long one requester can keep the grant, so no requester starves.

## Interface
- `MAX_HOLD`, default 8: maximum consecutive cycles one requester may hold a grant. Legal range 1..255.
- `clk`  input  1  sole clock; all state updates on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `req`  input  4  `req[i]` high means requester i wants mux input `in<i>` routed to `out`.
- `grant`  output  4  one-hot grant, or all-zero when no grant is active; registered.
- `address0`  output  1  mux select bit 0; registered.
- `address1`  output  1  mux select bit 1; registered. `{address1,address0}` is the granted index.
- `busy`  output  1  high while any grant is active; equals `|grant`.

## Operation
- **State:**
  - FSM with states IDLE and GRANT.
  - 2-bit owner index `own`.
  - 2-bit round-robin pointer `ptr`.
  - 8-bit hold counter `hcnt`.
- **Round-robin pick:** the first i with `req[i]`=1, scanning `ptr`, `ptr+1`, … mod 4.
- **IDLE:**
  - If `req`=0, stay in IDLE.
  - Otherwise:
    - pick by round-robin;
    - set `own`=pick, `grant`=1<<pick, `{address1,address0}`=pick;
    - set `hcnt`=1;
    - go to GRANT.
- **GRANT, keep:** if `req[own]`=1 and `hcnt`<`MAX_HOLD`, keep the grant and increment `hcnt`.
- **GRANT, release:** release when `req[own]`=0, or when `hcnt`=`MAX_HOLD` (forced release).
- **On release:**
  - Set `ptr`=`own`+1 mod 4.
  - Pick the next owner by round-robin from `own`+1, over `req` excluding `own`.
  - If another requester exists:
    - switch directly to it in the same edge, with no idle cycle;
    - set `hcnt`=1;
    - stay in GRANT.
  - If no other requester exists but `req[own]`=1 (forced release with a sole requester):
    - re-grant `own`;
    - set `hcnt`=1.
  - If `req`=0: set `grant`=0 and go to IDLE.
- **Select hold:** `{address1,address0}` keep the last granted index while in IDLE. This prevents select toggling when no one is granted.
- **Invariants:**
  - `grant` is always one-hot or zero.
  - When `grant`≠0, `grant[{address1,address0}]`=1.

## Timing
- **Reset values**, applied immediately on `rst_n` low with no clock needed:
  - `grant`=0000, `busy`=0, `address1`=0, `address0`=0;
  - state IDLE, `ptr`=0, `own`=0, `hcnt`=0.
- **Reset mid-grant:** all outputs drop at once. After `rst_n` rises, arbitration restarts with priority from `req[0]`.
- **Grant latency:** `req` sampled high at edge N (FSM idle) gives `grant`/`address*` valid after edge N. That is one cycle after request assertion.
- **Release latency:** `req[own]` sampled low at edge N gives the new grant, or `grant`=0, after edge N.
- **Hold limit:** with a continuous request and competitors present, one owner holds for exactly `MAX_HOLD` cycles.
- **`MAX_HOLD`=1:** the grant rotates every cycle among active requesters.
- **Select timing:** `address*` and `grant` change on the same edge. The mux gate delay (about 150 time units through NOT/AND/OR) must fit within the clock period. Bench clock period: 1000 time units.
- **Simultaneous events:**
  - A new `req` rising in the same cycle the owner releases takes part in that edge's pick.
  - A requester dropping `req` while not granted is simply ignored.

## Test plan
- **Reset:** assert `rst_n`=0 mid-grant (owner 2) → `grant`=0000, `address`=00, `busy`=0 immediately, with no clock edge.
- **Single request:** `req`=0100 from IDLE → after one edge, `grant`=0100, `{address1,address0}`=10, `busy`=1. Then `req`=0000 → `grant`=0000 after the next edge, address stays 10.
- **Simultaneous requests:** `req`=1111 from reset, `MAX_HOLD`=8, held continuously:
  - grants in order 0,1,2,3,0, each lasting exactly 8 cycles;
  - no idle cycle between owners.
- **Early release:** `req`=0011, owner 0 drops `req[0]` after 3 cycles → owner 1 granted on the next edge with `address`=01. When `req[1]` later drops and `req`=0000 → IDLE, then `req`=0001 → owner 0 granted.
- **Sole requester forced release:** `req`=1000 held for 20 cycles, `MAX_HOLD`=8 → `grant` stays 1000 continuously, with `hcnt` restarting every 8 cycles. Raise `req[1]` at cycle 12 → owner 1 granted at cycle 16.
- **Data path:** mux instantiated with `in0`..`in3`=0,1,0,1, `MAX_HOLD`=1, `req`=1111 → mux `out` alternates 0,1,0,1 each cycle. Check the one-hot invariant every cycle.
